spn_req_sched: RTL and testbench

//  Request scheduler sitting directly upstream of the SPN cryptographic unit. Buffers

---
 rtl/spn_req_sched.sv | 163 ++++++++++++++++
 tb/tb_spn_req_sched.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spn_req_sched.sv
// Request scheduler in front of the SPN core: buffers requests in a small FIFO, issues one at
// a time, waits (with timeout) for the core's completion code and holds the result for pickup.
module spn_req_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_opcode,
    input  logic [15:0]              req_data,
    input  logic [31:0]              req_key,
    output logic [1:0]               opcode,
    output logic [15:0]              in_data,
    output logic [31:0]              key,
    input  logic [15:0]              out_data,
    input  logic [1:0]               valid,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [15:0]              rsp_data,
    output logic [1:0]               rsp_status,
    output logic                     rsp_timeout,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     spurious
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int EW = 2 + 16 + 32;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [EW-1:0]   issue_reg;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [15:0]     rsp_data_reg;
    logic [1:0]      rsp_status_reg;
    logic            rsp_timeout_reg;
    logic            spurious_reg;
    logic            push, pop;
    logic            rsp_load, rsp_by_timeout;

    // Ready looks only at the current occupancy; a pop in the same cycle does not open a slot.
    assign req_ready = (count_reg != FULL_COUNT);
    assign push      = req_valid && req_ready && (req_opcode != 2'b00);
    assign pop       = (state_reg == S_IDLE) && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {req_opcode, req_data, req_key};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // The issue register doubles as the registered read port of the request store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_reg <= '0;
        end else if (pop) begin
            issue_reg <= mem[rd_ptr_reg];
        end
    end

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        rsp_load       = 1'b0;
        rsp_by_timeout = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (count_reg != '0) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_next = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                timer_next = timer_reg + 1'b1;
                // A core reply in the final wait cycle takes priority over the timeout.
                if (valid != 2'b00) begin
                    rsp_load   = 1'b1;
                    state_next = S_RESP;
                end else if (timer_reg == TIMER_LAST) begin
                    rsp_load       = 1'b1;
                    rsp_by_timeout = 1'b1;
                    state_next     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            timer_reg       <= '0;
            rsp_data_reg    <= '0;
            rsp_status_reg  <= '0;
            rsp_timeout_reg <= 1'b0;
            spurious_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            spurious_reg <= (valid != 2'b00) && (state_reg != S_WAIT);
            if (rsp_load) begin
                rsp_data_reg    <= rsp_by_timeout ? 16'h0000 : out_data;
                rsp_status_reg  <= rsp_by_timeout ? 2'b11 : valid;
                rsp_timeout_reg <= rsp_by_timeout;
            end
        end
    end

    assign opcode      = (state_reg == S_ISSUE) ? issue_reg[49:48] : 2'b00;
    assign in_data     = (state_reg == S_ISSUE || state_reg == S_WAIT) ? issue_reg[47:32] : 16'h0000;
    assign key         = (state_reg == S_ISSUE || state_reg == S_WAIT) ? issue_reg[31:0] : 32'h0000_0000;
    assign rsp_valid   = (state_reg == S_RESP);
    assign rsp_data    = rsp_data_reg;
    assign rsp_status  = rsp_status_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign fifo_count  = count_reg;
    assign busy        = (state_reg != S_IDLE);
    assign spurious    = spurious_reg;

endmodule

// File: tb/tb_spn_req_sched.sv
// Self-checking bench for spn_req_sched: directed vector table, hand-written corner sequences,
// and a randomized run scored against a queue-based model of the scheduler's rules.
module tb_spn_req_sched;

    localparam int D           = 4;
    localparam int T           = 32;
    localparam int RAND_CYCLES = 1500;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_opcode;
    logic [15:0] req_data;
    logic [31:0] req_key;
    logic [1:0]  opcode;
    logic [15:0] in_data;
    logic [31:0] key;
    logic [15:0] out_data;
    logic [1:0]  valid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        rsp_timeout;
    logic [2:0]  fifo_count;
    logic        busy;
    logic        spurious;

    spn_req_sched #(.DEPTH(D), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_data(req_data), .req_key(req_key),
        .opcode(opcode), .in_data(in_data), .key(key),
        .out_data(out_data), .valid(valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
        .fifo_count(fifo_count), .busy(busy), .spurious(spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic [31:0] k;
        int          lat;     // wait cycle in which the core replies; 0 = never
        logic [1:0]  code;
        logic [15:0] cout;
        logic [15:0] e_data;
        logic [1:0]  e_status;
        logic        e_to;
        int          e_lat;   // cycles from request acceptance to rsp_valid
    } vec_t;

    vec_t vecs[7];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ctx     = 0;
    bit          auto_core = 1'b0;
    bit          core_arm  = 1'b0;
    logic [15:0] core_out  = '0;

    // randomized-phase model state
    logic [49:0] mq[$];
    logic [49:0] cur, push_val;
    bit          inflight, issue_next, push_pending, hs_pending, draining, exp_rv, exp_hold;
    int          issue_cyc, reply_cyc, spur_cyc, eff, lat, r, n_rsp;
    logic [1:0]  reply_code, e_st, exp_op;
    logic [15:0] reply_data, e_data;
    logic        e_to;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [ctx %0d cyc %0d]: got %0h, expected %0h", name, ctx, cyc, act, exp);
        end
    endtask

    // Advance one clock and settle; optionally act as a core replying one cycle after issue.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_core) begin
            valid = 2'b00;
            if (core_arm) begin
                valid    = 2'b01;
                out_data = core_out;
                core_arm = 1'b0;
            end
            if (opcode != 2'b00) begin
                core_arm = 1'b1;
                core_out = in_data ^ 16'h5A5A;
            end
        end
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_opcode = 2'b00;
        req_data   = '0;
        req_key    = '0;
        out_data   = '0;
        valid      = 2'b00;
        rsp_ready  = 1'b0;
        core_arm   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_in_data", in_data, 0);
        chk("rst_key", key, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_spurious", spurious, 0);
        chk("rst_rsp_fields", {rsp_data, rsp_status, rsp_timeout}, 0);
        reset = 1'b1;
        step();
    endtask

    task automatic run_vec(input vec_t v);
        int s0;
        bit got;
        s0 = cyc;
        chk("vec_ready", req_ready, 1);
        req_valid = 1'b1; req_opcode = v.op; req_data = v.data; req_key = v.k;
        step();
        req_valid = 1'b0;
        if (v.op == 2'b00) begin
            for (int i = 0; i < 3; i++) begin
                chk("nop_count", fifo_count, 0);
                chk("nop_busy", busy, 0);
                chk("nop_opcode", opcode, 0);
                step();
            end
            $display("[TB] vec %0d: opcode 00 request discarded", ctx);
            return;
        end
        chk("vec_count", fifo_count, 1);
        step();
        chk("vec_issue_op", opcode, v.op);
        chk("vec_issue_data", in_data, v.data);
        chk("vec_issue_key", key, v.k);
        got = 1'b0;
        for (int k = 1; k <= T + 3; k++) begin
            step();
            valid = 2'b00;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (k == 1) begin
                chk("vec_wait_op", opcode, 0);
                chk("vec_wait_data", in_data, v.data);
                chk("vec_wait_key", key, v.k);
            end
            if (k == v.lat) begin
                valid    = v.code;
                out_data = v.cout;
            end
        end
        chk("vec_got_rsp", got, 1);
        chk("vec_latency", cyc - s0, v.e_lat);
        chk("vec_rsp_data", rsp_data, v.e_data);
        chk("vec_rsp_status", rsp_status, v.e_status);
        chk("vec_rsp_timeout", rsp_timeout, v.e_to);
        $display("[TB] vec %0d: op=%b data=%h -> rsp data=%h status=%b timeout=%b after %0d cycles",
                 ctx, v.op, v.data, rsp_data, rsp_status, rsp_timeout, cyc - s0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("vec_rsp_drop", rsp_valid, 0);
        chk("vec_idle", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{2'b01, 16'h1234, 32'hA5A5_0F0F, 2,     2'b01, 16'hBEEF, 16'hBEEF, 2'b01, 1'b0, 5};
        vecs[1] = '{2'b10, 16'hCAFE, 32'h0123_4567, 1,     2'b10, 16'h0F0F, 16'h0F0F, 2'b10, 1'b0, 4};
        vecs[2] = '{2'b11, 16'h5555, 32'hFFFF_0000, 3,     2'b11, 16'h1357, 16'h1357, 2'b11, 1'b0, 6};
        vecs[3] = '{2'b01, 16'h0001, 32'h0000_0000, 4,     2'b11, 16'hAAAA, 16'hAAAA, 2'b11, 1'b0, 7};
        vecs[4] = '{2'b10, 16'h7777, 32'h1234_5678, T,     2'b10, 16'h4242, 16'h4242, 2'b10, 1'b0, T + 3};
        vecs[5] = '{2'b01, 16'h9999, 32'h8765_4321, 0,     2'b00, 16'h0000, 16'h0000, 2'b11, 1'b1, T + 3};
        vecs[6] = '{2'b00, 16'hFACE, 32'hDEAD_BEEF, 0,     2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 0};

        idle_inputs();
        reset = 1'b0;
        do_reset();

        for (int i = 0; i < 7; i++) begin
            ctx = i;
            run_vec(vecs[i]);
        end

        // Fill the FIFO while the first response is held, then drain in order.
        ctx = 50;
        do_reset();
        auto_core = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("fill_ready", req_ready, 1);
            req_valid = 1'b1; req_opcode = 2'b01; req_data = 16'h1000 + 16'(i); req_key = 32'(i);
            step();
        end
        chk("fill_count", fifo_count, 4);
        chk("fill_ready_low", req_ready, 0);
        chk("fill_busy", busy, 1);
        req_data = 16'h1005;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fill_no_bypass", fifo_count, 4);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 200 && n < 5; i++) begin
            if (rsp_valid) begin
                chk("fill_order", rsp_data, (16'h1000 + 16'(n)) ^ 16'h5A5A);
                chk("fill_status", rsp_status, 2'b01);
                $display("[TB] fill rsp %0d: data=%h status=%b", n, rsp_data, rsp_status);
                n++;
            end
            if (n < 5) step();
        end
        chk("fill_all_rsp", n, 5);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("fill_extra_rsp", rsp_valid, 0);
        end
        chk("fill_ready_back", req_ready, 1);
        chk("fill_empty", fifo_count, 0);
        auto_core = 1'b0;
        rsp_ready = 1'b0;

        // Timeout, late reply, backpressure, then reset during WAIT.
        ctx = 60;
        do_reset();
        req_valid = 1'b1; req_opcode = 2'b01; req_data = 16'h3333; req_key = 32'h3333_3333;
        step();
        req_valid = 1'b0;
        step();
        chk("to_issue", opcode, 2'b01);
        for (int k = 1; k <= T; k++) step();
        chk("to_not_early", rsp_valid, 0);
        step();
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_data", rsp_data, 0);
        chk("to_rsp_status", rsp_status, 2'b11);
        chk("to_rsp_timeout", rsp_timeout, 1);
        $display("[TB] timeout rsp: data=%h status=%b timeout=%b", rsp_data, rsp_status, rsp_timeout);
        valid = 2'b01; out_data = 16'hFFFF;
        step();
        valid = 2'b00;
        chk("late_spurious", spurious, 1);
        chk("late_rsp_data", rsp_data, 0);
        chk("late_rsp_status", rsp_status, 2'b11);
        chk("late_rsp_timeout", rsp_timeout, 1);
        req_valid = 1'b1; req_opcode = 2'b10; req_data = 16'h4444; req_key = 32'h4444_4444;
        step();
        req_valid = 1'b0;
        chk("late_spurious_end", spurious, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_status", rsp_status, 2'b11);
            chk("bp_no_issue", opcode, 0);
            chk("bp_count", fifo_count, 1);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_release", rsp_valid, 0);
        step();
        chk("bp_next_issue", opcode, 2'b10);
        chk("bp_next_data", in_data, 16'h4444);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("midrst_in_data", in_data, 0);
        chk("midrst_key", key, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_count", fifo_count, 0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("midrst_ready", req_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("midrst_quiet", {rsp_valid, busy, opcode}, 0);
        end
        valid = 2'b10;
        step();
        valid = 2'b00;
        chk("idle_spurious", spurious, 1);
        step();
        chk("idle_spurious_end", spurious, 0);

        // Randomized run against the queue model.
        ctx = 200;
        do_reset();
        mq.delete();
        inflight = 0; issue_next = 0; push_pending = 0; hs_pending = 0;
        spur_cyc = -1; reply_cyc = -1; n_rsp = 0; issue_cyc = 0; eff = 0;
        cur = '0; e_data = '0; e_st = '0; e_to = 0;
        for (int it = 0; it < RAND_CYCLES + 400; it++) begin
            if (issue_next) begin
                cur = mq.pop_front();
                inflight = 1'b1;
                issue_cyc = cyc;
                r = $urandom_range(0, 3);
                if (r == 0) lat = 0;
                else if (r == 1) lat = $urandom_range(T - 1, T + 2);
                else lat = $urandom_range(1, 8);
                reply_code = 2'($urandom_range(1, 3));
                reply_data = 16'($urandom);
                if (lat == 0 || lat > T) begin
                    e_data = '0; e_st = 2'b11; e_to = 1'b1; eff = T;
                end else begin
                    e_data = reply_data; e_st = reply_code; e_to = 1'b0; eff = lat;
                end
                reply_cyc = (lat == 0) ? -1 : issue_cyc + lat;
            end
            if (hs_pending) begin
                inflight = 1'b0;
                $display("[TB] rand rsp %0d: op=%b data=%h -> %h status=%b timeout=%b",
                         n_rsp, cur[49:48], cur[47:32], e_data, e_st, e_to);
                n_rsp++;
            end
            if (push_pending) mq.push_back(push_val);

            exp_op   = (inflight && cyc == issue_cyc) ? cur[49:48] : 2'b00;
            exp_hold = inflight && (cyc <= issue_cyc + eff);
            exp_rv   = inflight && (cyc > issue_cyc + eff);
            chk("rand_count", fifo_count, mq.size());
            chk("rand_ready", req_ready, mq.size() < D);
            chk("rand_busy", busy, inflight);
            chk("rand_opcode", opcode, exp_op);
            chk("rand_in_data", in_data, exp_hold ? cur[47:32] : 16'h0000);
            chk("rand_key", key, exp_hold ? cur[31:0] : 32'h0);
            chk("rand_rsp_valid", rsp_valid, exp_rv);
            chk("rand_spurious", spurious, cyc == spur_cyc);
            if (exp_rv) begin
                chk("rand_rsp_data", rsp_data, e_data);
                chk("rand_rsp_status", rsp_status, e_st);
                chk("rand_rsp_timeout", rsp_timeout, e_to);
            end
            issue_next = !inflight && (mq.size() > 0);

            draining = (it >= RAND_CYCLES);
            if (draining && !inflight && mq.size() == 0) break;
            req_valid  = !draining && ($urandom_range(0, 2) != 0);
            req_opcode = 2'($urandom_range(0, 3));
            req_data   = 16'($urandom);
            req_key    = $urandom;
            push_pending = req_valid && (mq.size() < D) && (req_opcode != 2'b00);
            push_val     = {req_opcode, req_data, req_key};
            rsp_ready  = draining || ($urandom_range(0, 2) == 0);
            hs_pending = exp_rv && rsp_ready;
            if (cyc == reply_cyc) begin
                valid    = reply_code;
                out_data = reply_data;
                if (reply_cyc > issue_cyc + T) spur_cyc = cyc + 1;
            end else begin
                valid    = 2'b00;
                out_data = 16'($urandom);
            end
            step();
        end
        chk("rand_queue_left", mq.size(), 0);
        chk("rand_inflight_left", inflight, 0);
        chk("rand_rsp_seen", n_rsp > 10, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
